// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-write port between four rectangle
// drawers; the granted rectangle is raster-filled one pixel per clock.
module draw_port_arbiter #(
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] rect_x0,
  input  logic [27:0] rect_y0,
  input  logic [31:0] rect_x1,
  input  logic [27:0] rect_y1,
  input  logic [11:0] rect_colour,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic        plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour
);

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [7:0] x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
  logic [6:0] y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
  logic [2:0] col_q, col_d;

  logic       win_found;
  logic [1:0] win_idx, scan_idx, g_idx;
  logic [7:0] sel_x0, sel_x1, x1_clamp;
  logic [6:0] sel_y0, sel_y1, y1_clamp;
  logic [2:0] sel_col;
  logic       rect_empty, row_end, last_pix;

  // Scan starts one past the most recently served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    g_idx   = 2'd0;
    sel_x0  = 8'd0;
    sel_x1  = 8'd0;
    sel_y0  = 7'd0;
    sel_y1  = 7'd0;
    sel_col = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        g_idx   = 2'(i);
        sel_x0  = rect_x0[8*i +: 8];
        sel_x1  = rect_x1[8*i +: 8];
        sel_y0  = rect_y0[7*i +: 7];
        sel_y1  = rect_y1[7*i +: 7];
        sel_col = rect_colour[3*i +: 3];
      end
    end
  end

  assign x1_clamp   = (sel_x1 > XM) ? XM : sel_x1;
  assign y1_clamp   = (sel_y1 > YM) ? YM : sel_y1;
  assign rect_empty = (sel_x0 > x1_clamp) || (sel_y0 > y1_clamp) ||
                      (sel_x0 > XM) || (sel_y0 > YM);
  assign row_end    = (cur_x_q == x1_q);
  assign last_pix   = row_end && (cur_y_q == y1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 4'd0;
      last_q  <= 2'd3;
      x0_q    <= 8'd0;
      x1_q    <= 8'd0;
      y0_q    <= 7'd0;
      y1_q    <= 7'd0;
      cur_x_q <= 8'd0;
      cur_y_q <= 7'd0;
      col_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_LATCH;
      S_LATCH: state_d = rect_empty ? S_DONE : S_DRAW;
      S_DRAW:  if (last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: grant_d = win_found ? (4'b0001 << win_idx) : 4'b0000;
      S_LATCH: begin
        x0_d    = sel_x0;
        x1_d    = x1_clamp;
        y0_d    = sel_y0;
        y1_d    = y1_clamp;
        col_d   = sel_col;
        cur_x_d = sel_x0;
        cur_y_d = sel_y0;
      end
      S_DRAW: begin
        if (row_end) begin
          cur_x_d = x0_q;
          cur_y_d = cur_y_q + 7'd1;
        end else begin
          cur_x_d = cur_x_q + 8'd1;
        end
      end
      S_DONE: begin
        last_d  = g_idx;
        grant_d = 4'b0000;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    plot       = (state_q == S_DRAW);
    done       = (state_q == S_DONE) ? grant_q : 4'b0000;
    grant      = grant_q;
    vga_x      = cur_x_q;
    vga_y      = cur_y_q;
    vga_colour = col_q;
  end

endmodule
